// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control sequencer
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    output logic             pc_we,
    output logic             ir_we,
    output logic             iord,
    output logic             mem_re,
    output logic             mem_we,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        R_EXEC   = 4'd7,
        R_WB     = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        I_EXEC   = 4'd11,
        I_WB     = 4'd12,
        HALT     = 4'd13
    } state_t;

    state_t cur, nxt;
    logic   retire;
    logic   r_legal;

    assign state = cur;

    always_comb begin
        r_legal = 1'b0;
        case (func)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: r_legal = 1'b1;
            default:                           r_legal = 1'b0;
        endcase
    end

    // Every completing state returns to FETCH unconditionally, so leaving one is a retirement.
    always_comb begin
        retire = 1'b0;
        case (cur)
            MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, I_WB: retire = 1'b1;
            default:                                  retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= IDLE;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (cur == DECODE && nxt == HALT)
                illegal <= 1'b1;
            if (retire)
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        nxt        = cur;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        iord       = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        pc_src     = 2'b00;
        case (cur)
            IDLE: nxt = FETCH;
            FETCH: begin
                mem_re    = 1'b1;
                ir_we     = 1'b1;
                alu_src_b = 2'b01;
                pc_we     = 1'b1;
                nxt       = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    6'h23, 6'h2B: nxt = MEM_ADDR;
                    6'h00:        nxt = r_legal ? R_EXEC : HALT;
                    6'h04:        nxt = BRANCH;
                    6'h02:        nxt = JUMP;
                    6'h08:        nxt = I_EXEC;
                    default:      nxt = HALT;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (op == 6'h23) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_re = 1'b1;
                iord   = 1'b1;
                nxt    = MEM_WB;
            end
            MEM_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                nxt        = FETCH;
            end
            MEM_WR: begin
                mem_we = 1'b1;
                iord   = 1'b1;
                nxt    = FETCH;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                case (func)
                    6'h22:   alu_op = 3'b001;
                    6'h24:   alu_op = 3'b010;
                    6'h25:   alu_op = 3'b011;
                    6'h2A:   alu_op = 3'b100;
                    default: alu_op = 3'b000;
                endcase
                nxt = R_WB;
            end
            R_WB: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
                nxt     = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b001;
                pc_src    = 2'b01;
                pc_we     = zero;
                nxt       = FETCH;
            end
            JUMP: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
                nxt    = FETCH;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = I_WB;
            end
            I_WB: begin
                reg_we = 1'b1;
                nxt    = FETCH;
            end
            HALT:    nxt = HALT;
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'h00;
    logic [5:0] func = 6'h00;
    logic       zero = 1'b0;
    logic       pc_we, ir_we, iord, mem_re, mem_we, reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       illegal;
    logic [3:0] retired;

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
        .pc_we(pc_we), .ir_we(ir_we), .iord(iord), .mem_re(mem_re), .mem_we(mem_we),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [5:0]      op;
        logic [5:0]      func;
        logic            zero;
        int              cpi;
        logic [5:0][3:0] st;
        logic [2:0]      ralu;
    } vec_t;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctl;
    } sb_t;

    vec_t tbl[11];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] exp_ret = 4'd0;

    function automatic logic [15:0] act_ctl();
        return {pc_we, ir_we, iord, mem_re, mem_we, reg_we, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, pc_src};
    endfunction

    // Reference controls per state, written straight from the state table.
    function automatic logic [15:0] ref_ctl(input logic [3:0] s, input logic [2:0] ralu, input logic z);
        logic pw, iw, io, mr, mw, rw, rd, m2r, sa;
        logic [1:0] sbv, ps;
        logic [2:0] ao;
        {pw, iw, io, mr, mw, rw, rd, m2r, sa} = '0;
        sbv = 2'b00; ps = 2'b00; ao = 3'b000;
        case (s)
            4'd1:  begin mr = 1; iw = 1; sbv = 2'b01; pw = 1; end
            4'd2:  sbv = 2'b11;
            4'd3:  begin sa = 1; sbv = 2'b10; end
            4'd4:  begin mr = 1; io = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mw = 1; io = 1; end
            4'd7:  begin sa = 1; ao = ralu; end
            4'd8:  begin rw = 1; rd = 1; end
            4'd9:  begin sa = 1; ao = 3'b001; ps = 2'b01; pw = z; end
            4'd10: begin ps = 2'b10; pw = 1; end
            4'd11: begin sa = 1; sbv = 2'b10; end
            4'd12: rw = 1;
            default: ;
        endcase
        return {pw, iw, io, mr, mw, rw, rd, m2r, sa, sbv, ao, ps};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the next FETCH negedge.
    task automatic run_instr(input vec_t v);
        sb_t e;
        op = v.op; func = v.func; zero = v.zero;
        for (int i = 0; i < v.cpi; i++) begin
            e.st  = v.st[i];
            e.ctl = ref_ctl(v.st[i], v.ralu, v.zero);
            sb.push_back(e);
        end
        for (int i = 0; i < v.cpi; i++) begin
            e = sb.pop_front();
            check($sformatf("%s state[%0d]", v.name, i), {28'd0, state}, {28'd0, e.st});
            check($sformatf("%s ctl[%0d]", v.name, i), {16'd0, act_ctl()}, {16'd0, e.ctl});
            @(posedge clk);
            @(negedge clk);
        end
        exp_ret = exp_ret + 4'd1;
        check($sformatf("%s retired", v.name), {28'd0, retired}, {28'd0, exp_ret});
        check($sformatf("%s next fetch", v.name), {28'd0, state}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t j;
        tbl[0]  = '{"addi",  6'h08, 6'h00, 1'b0, 4, {4'd0, 4'd0, 4'd12, 4'd11, 4'd2, 4'd1}, 3'b000};
        tbl[1]  = '{"lw",    6'h23, 6'h00, 1'b0, 5, {4'd0, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1},   3'b000};
        tbl[2]  = '{"sw",    6'h2B, 6'h00, 1'b0, 4, {4'd0, 4'd0, 4'd6, 4'd3, 4'd2, 4'd1},   3'b000};
        tbl[3]  = '{"slt",   6'h00, 6'h2A, 1'b0, 4, {4'd0, 4'd0, 4'd8, 4'd7, 4'd2, 4'd1},   3'b100};
        tbl[4]  = '{"sub",   6'h00, 6'h22, 1'b0, 4, {4'd0, 4'd0, 4'd8, 4'd7, 4'd2, 4'd1},   3'b001};
        tbl[5]  = '{"and",   6'h00, 6'h24, 1'b0, 4, {4'd0, 4'd0, 4'd8, 4'd7, 4'd2, 4'd1},   3'b010};
        tbl[6]  = '{"or",    6'h00, 6'h25, 1'b0, 4, {4'd0, 4'd0, 4'd8, 4'd7, 4'd2, 4'd1},   3'b011};
        tbl[7]  = '{"add",   6'h00, 6'h20, 1'b0, 4, {4'd0, 4'd0, 4'd8, 4'd7, 4'd2, 4'd1},   3'b000};
        tbl[8]  = '{"beq_t", 6'h04, 6'h00, 1'b1, 3, {4'd0, 4'd0, 4'd0, 4'd9, 4'd2, 4'd1},   3'b000};
        tbl[9]  = '{"beq_n", 6'h04, 6'h00, 1'b0, 3, {4'd0, 4'd0, 4'd0, 4'd9, 4'd2, 4'd1},   3'b000};
        tbl[10] = '{"j",     6'h02, 6'h00, 1'b0, 3, {4'd0, 4'd0, 4'd0, 4'd10, 4'd2, 4'd1},  3'b000};
        j = tbl[10];

        @(negedge clk);
        check("reset state", {28'd0, state}, 32'd0);
        check("reset ctl", {16'd0, act_ctl()}, 32'd0);
        check("reset illegal", {31'd0, illegal}, 32'd0);
        check("reset retired", {28'd0, retired}, 32'd0);
        rst = 1'b0;
        #1 check("idle after reset", {28'd0, state}, 32'd0);
        @(negedge clk);
        check("first fetch", {28'd0, state}, 32'd1);

        for (int i = 0; i < 11; i++) run_instr(tbl[i]);

        // Five more jumps take the 4-bit counter from 11 through 15 and wrap to 0.
        for (int i = 0; i < 5; i++) run_instr(j);
        check("retired wrap", {28'd0, retired}, 32'd0);

        op = 6'h23; func = 6'h00;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        check("pre-reset in MEM_RD", {28'd0, state}, 32'd4);
        rst = 1'b1;
        #1;
        check("async reset state", {28'd0, state}, 32'd0);
        check("async reset ctl", {16'd0, act_ctl()}, 32'd0);
        check("async reset retired", {28'd0, retired}, 32'd0);
        exp_ret = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("fetch after reset", {28'd0, state}, 32'd1);
        run_instr(tbl[1]);

        op = 6'h3F; func = 6'h00;
        @(posedge clk); @(negedge clk);
        check("illegal decode", {28'd0, state}, 32'd2);
        check("illegal not yet set", {31'd0, illegal}, 32'd0);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            zero = i[0];
            check($sformatf("halt state[%0d]", i), {28'd0, state}, 32'd13);
            check($sformatf("halt ctl[%0d]", i), {16'd0, act_ctl()}, 32'd0);
            check($sformatf("halt illegal[%0d]", i), {31'd0, illegal}, 32'd1);
            check($sformatf("halt retired[%0d]", i), {28'd0, retired}, {28'd0, exp_ret});
            @(posedge clk); @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
